// File: rtl/router_fsm.sv
// router_fsm: control FSM for the 1x3 packet router (header decode, payload/parity load sequencing)
// Ports: clk, rst (sync, active-high); pkt_valid, din, fifo_full, fifo_empty_0..2, soft_reset_0..2,
// parity_done, low_pkt_valid in; write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
// full_state, rst_int_reg, busy out. Define ROUTER_FSM_DBG_EN to add state_dbg[2:0].
module router_fsm #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] din,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_reset_0,
  input  logic              soft_reset_1,
  input  logic              soft_reset_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              write_enb_reg,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy
`ifdef ROUTER_FSM_DBG_EN
  ,
  output logic [2:0]        state_dbg
`endif
);
  localparam int N = 2 ** ADDR_W;
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    WAIT_TILL_EMPTY    = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    LOAD_PARITY        = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [N-1:0] empty_v, srst_v;
  logic din_ok;
  // zero-extended so the invalid address 3 indexes a harmless 0
  assign empty_v = N'({fifo_empty_2, fifo_empty_1, fifo_empty_0});
  assign srst_v  = N'({soft_reset_2, soft_reset_1, soft_reset_0});
  assign din_ok  = din != ADDR_W'(3);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q != DECODE_ADDRESS && srst_v[addr_q]) state_d = DECODE_ADDRESS;
    else
      case (state_q)
        DECODE_ADDRESS:
          if (pkt_valid && din_ok) begin
            addr_d  = din;
            state_d = empty_v[din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        WAIT_TILL_EMPTY:    state_d = empty_v[addr_q] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:    state_d = LOAD_DATA;
        LOAD_DATA:          state_d = fifo_full ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
        FIFO_FULL_STATE:    state_d = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:    state_d = parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:            state_d = DECODE_ADDRESS;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end
  assign detect_add    = state_q == DECODE_ADDRESS;
  assign lfd_state     = state_q == LOAD_FIRST_DATA;
  assign ld_state      = state_q == LOAD_DATA;
  assign laf_state     = state_q == LOAD_AFTER_FULL;
  assign full_state    = state_q == FIFO_FULL_STATE;
  assign rst_int_reg   = state_q == CHECK_PARITY_ERROR;
  assign write_enb_reg = ld_state || laf_state || state_q == LOAD_PARITY;
  assign busy          = !(detect_add || ld_state);
`ifdef ROUTER_FSM_DBG_EN
  assign state_dbg = state_q;
`endif
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: table-driven directed bench for router_fsm
module tb_router_fsm;
  logic clk = 0, rst = 1, pkt_valid = 0, fifo_full = 0;
  logic [1:0] din = '0;
  logic [2:0] emp = '0, srs = '0;
  logic parity_done = 0, low_pkt_valid = 0;
  logic write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;
  logic [7:0] got;
  int checks = 0, failures = 0;
`ifdef ROUTER_FSM_DBG_EN
  logic [2:0] state_dbg;
`endif
  router_fsm dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .fifo_full(fifo_full),
    .fifo_empty_0(emp[0]), .fifo_empty_1(emp[1]), .fifo_empty_2(emp[2]),
    .soft_reset_0(srs[0]), .soft_reset_1(srs[1]), .soft_reset_2(srs[2]),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy)
`ifdef ROUTER_FSM_DBG_EN
    , .state_dbg(state_dbg)
`endif
  );
  always #5 clk = ~clk;
  assign got = {write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};
  // {we, det, lfd, ld, laf, full, rint, busy} expected per state
  localparam logic [7:0] DEC = 8'b0100_0000, LFD = 8'b0010_0001, LD = 8'b1001_0000,
                         WT = 8'b0000_0001, FUL = 8'b0000_0101, LAF = 8'b1000_1001,
                         LP = 8'b1000_0001, CHK = 8'b0000_0011;
  typedef struct {
    logic r, pv;
    logic [1:0] d;
    logic f;
    logic [2:0] e, s;
    logic pd, lp;
    logic [7:0] x;
  } vec_t;
  vec_t v[$];
  task automatic add(input logic r, pv, input logic [1:0] d, input logic f,
                     input logic [2:0] e, s, input logic pd, lp, input logic [7:0] x);
    v.push_back('{r, pv, d, f, e, s, pd, lp, x});
  endtask
  task automatic step(input vec_t t);
    rst = t.r; pkt_valid = t.pv; din = t.d; fifo_full = t.f; emp = t.e; srs = t.s;
    parity_done = t.pd; low_pkt_valid = t.lp;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [7:0] g, input logic [7:0] x);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL %s: got %b expected %b", n, g, x);
    end
  endtask
  initial begin
    add(1, 0, 0, 0, 3'b000, 0, 0, 0, DEC);
    add(1, 0, 0, 0, 3'b000, 0, 0, 0, DEC);
    add(0, 0, 0, 0, 3'b000, 0, 0, 0, DEC);
    add(0, 0, 0, 0, 3'b111, 0, 0, 0, DEC);
    add(0, 1, 1, 0, 3'b010, 0, 0, 0, LFD);
    for (int i = 0; i < 8; i++) add(0, 1, 1, 0, 3'b000, 0, 0, 0, LD);
    add(0, 0, 0, 0, 3'b000, 0, 0, 0, LP);
    add(0, 0, 0, 0, 3'b000, 0, 0, 0, CHK);
    add(0, 0, 0, 0, 3'b000, 0, 0, 0, DEC);
    add(0, 1, 2, 0, 3'b011, 0, 0, 0, WT);
    for (int i = 0; i < 3; i++) add(0, 1, 2, 0, 3'b011, 3'b011, 0, 0, WT);
    add(0, 1, 2, 0, 3'b100, 0, 0, 0, LFD);
    add(0, 1, 2, 0, 3'b000, 0, 0, 0, LD);
    for (int i = 0; i < 3; i++) add(0, 1, 2, 1, 3'b000, 0, 0, 0, FUL);
    add(0, 1, 2, 0, 3'b000, 0, 0, 0, LAF);
    add(0, 1, 2, 0, 3'b000, 0, 0, 0, LD);
    add(0, 0, 2, 1, 3'b000, 0, 0, 0, FUL);
    add(0, 0, 2, 0, 3'b000, 0, 0, 0, LAF);
    add(0, 0, 2, 0, 3'b000, 0, 0, 1, LP);
    add(0, 0, 2, 1, 3'b000, 0, 0, 0, CHK);
    add(0, 0, 2, 1, 3'b000, 0, 0, 0, FUL);
    add(0, 0, 2, 0, 3'b000, 0, 0, 0, LAF);
    add(0, 0, 2, 0, 3'b000, 0, 1, 1, DEC);
    add(0, 1, 3, 0, 3'b111, 0, 0, 0, DEC);
    add(0, 1, 3, 0, 3'b111, 0, 0, 0, DEC);
    add(0, 1, 0, 0, 3'b001, 0, 0, 0, LFD);
    add(0, 1, 0, 0, 3'b000, 0, 0, 0, LD);
    add(0, 1, 0, 0, 3'b000, 3'b110, 0, 0, LD);
    add(0, 1, 0, 0, 3'b000, 3'b001, 0, 0, DEC);
    add(0, 0, 0, 0, 3'b000, 3'b001, 0, 0, DEC);
    foreach (v[i]) begin
      step(v[i]);
      chk($sformatf("vec%0d", i), got, v[i].x);
    end
    // reset mid-payload, with every other input pushing elsewhere
    step('{0, 1, 1, 0, 3'b010, 3'b000, 0, 0, 8'h00});
    chk("rst_seq_lfd", got, LFD);
    step('{0, 1, 1, 0, 3'b000, 3'b000, 0, 0, 8'h00});
    chk("rst_seq_ld", got, LD);
    step('{1, 1, 2, 1, 3'b111, 3'b000, 1, 1, 8'h00});
    chk("rst_seq_mid", got, DEC);
`ifdef ROUTER_FSM_DBG_EN
    checks++;
    if (state_dbg !== 3'd0) begin
      failures++;
      $display("FAIL state_dbg: got %0d expected 0", state_dbg);
    end
`endif
    step('{0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 8'h00});
    chk("rst_seq_idle", got, DEC);
    // after reset the saved address is 0: a full-FIFO header to 2 waits on FIFO 2 only
    step('{0, 1, 2, 0, 3'b001, 3'b000, 0, 0, 8'h00});
    chk("rst_seq_wait", got, WT);
    step('{0, 1, 2, 0, 3'b100, 3'b000, 0, 0, 8'h00});
    chk("rst_seq_go", got, LFD);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
